// File: rtl/scr1_tb_axi_arb_pkg.sv
// Shared types and helpers for the testbench AXI arbiter.
package scr1_tb_axi_arb_pkg;

    typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_e;
    typedef enum logic [1:0] {WR_IDLE, WR_XFER, WR_RESP} wr_state_e;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

    // Operands are each below n, so one conditional subtract is enough.
    function automatic int rr_wrap(input int v, input int n);
        return (v >= n) ? v - n : v;
    endfunction

endpackage

// File: rtl/scr1_tb_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module scr1_tb_rr_picker
    import scr1_tb_axi_arb_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int W_IDX = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [W_IDX-1:0] ptr,
    output logic [W_IDX-1:0] gnt_idx,
    output logic             any
);

    logic [W_IDX-1:0] cand;

    // Scan from the farthest offset down so the nearest hit to ptr is written last.
    always_comb begin
        gnt_idx = '0;
        any     = 1'b0;
        cand    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand = W_IDX'(rr_wrap(int'(ptr) + i, N_REQ));
            if (req[cand]) begin
                gnt_idx = cand;
                any     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/scr1_tb_axi_arbiter.sv
// N_REQ:1 single-beat AXI4 arbiter with independent round-robin read and write paths.
module scr1_tb_axi_arbiter
    import scr1_tb_axi_arb_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int W_ID   = 4,
    parameter int W_ADR  = 32,
    parameter int W_DATA = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_awvalid [N_REQ],
    input  logic [W_ID-1:0]         s_awid    [N_REQ],
    input  logic [W_ADR-1:0]        s_awaddr  [N_REQ],
    input  logic [2:0]              s_awsize  [N_REQ],
    input  logic [7:0]              s_awlen   [N_REQ],
    output logic                    s_awready [N_REQ],
    input  logic                    s_wvalid  [N_REQ],
    input  logic [W_DATA-1:0]       s_wdata   [N_REQ],
    input  logic [W_DATA/8-1:0]     s_wstrb   [N_REQ],
    input  logic                    s_wlast   [N_REQ],
    output logic                    s_wready  [N_REQ],
    input  logic                    s_bready  [N_REQ],
    output logic                    s_bvalid  [N_REQ],
    output logic [W_ID-1:0]         s_bid     [N_REQ],
    output logic [1:0]              s_bresp   [N_REQ],
    input  logic                    s_arvalid [N_REQ],
    input  logic [W_ID-1:0]         s_arid    [N_REQ],
    input  logic [W_ADR-1:0]        s_araddr  [N_REQ],
    input  logic [1:0]              s_arburst [N_REQ],
    input  logic [2:0]              s_arsize  [N_REQ],
    input  logic [7:0]              s_arlen   [N_REQ],
    output logic                    s_arready [N_REQ],
    input  logic                    s_rready  [N_REQ],
    output logic                    s_rvalid  [N_REQ],
    output logic [W_ID-1:0]         s_rid     [N_REQ],
    output logic [W_DATA-1:0]       s_rdata   [N_REQ],
    output logic                    s_rlast   [N_REQ],
    output logic [1:0]              s_rresp   [N_REQ],
    output logic                    m_awvalid,
    output logic [W_ID-1:0]         m_awid,
    output logic [W_ADR-1:0]        m_awaddr,
    output logic [2:0]              m_awsize,
    output logic [7:0]              m_awlen,
    input  logic                    m_awready,
    output logic                    m_wvalid,
    output logic [W_DATA-1:0]       m_wdata,
    output logic [W_DATA/8-1:0]     m_wstrb,
    output logic                    m_wlast,
    input  logic                    m_wready,
    input  logic                    m_bvalid,
    input  logic [W_ID-1:0]         m_bid,
    input  logic [1:0]              m_bresp,
    output logic                    m_bready,
    output logic                    m_arvalid,
    output logic [W_ID-1:0]         m_arid,
    output logic [W_ADR-1:0]        m_araddr,
    output logic [1:0]              m_arburst,
    output logic [2:0]              m_arsize,
    output logic [7:0]              m_arlen,
    input  logic                    m_arready,
    input  logic                    m_rvalid,
    input  logic [W_ID-1:0]         m_rid,
    input  logic [W_DATA-1:0]       m_rdata,
    input  logic                    m_rlast,
    input  logic [1:0]              m_rresp,
    output logic                    m_rready,
    output logic                    rd_busy,
    output logic                    wr_busy,
    output logic [$clog2(N_REQ)-1:0] rd_gnt_idx,
    output logic [$clog2(N_REQ)-1:0] wr_gnt_idx
);

    localparam int W_IDX = $clog2(N_REQ);

    rd_state_e        rd_state_q, rd_state_d;
    wr_state_e        wr_state_q, wr_state_d;
    logic [W_IDX-1:0] rd_gnt_q, rd_gnt_d, wr_gnt_q, wr_gnt_d;
    logic [W_IDX-1:0] rr_rd_q, rr_rd_d, rr_wr_q, rr_wr_d;
    logic             aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [W_ID-1:0]  arid_q, arid_d, awid_q, awid_d;

    logic [N_REQ-1:0] rd_req, wr_req;
    logic [W_IDX-1:0] rd_pick, wr_pick;
    logic             rd_any, wr_any;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            rd_req[i] = s_arvalid[i];
            wr_req[i] = s_awvalid[i];
        end
    end

    scr1_tb_rr_picker #(.N_REQ(N_REQ), .W_IDX(W_IDX)) u_rd_pick (
        .req     (rd_req),
        .ptr     (rr_rd_q),
        .gnt_idx (rd_pick),
        .any     (rd_any)
    );

    scr1_tb_rr_picker #(.N_REQ(N_REQ), .W_IDX(W_IDX)) u_wr_pick (
        .req     (wr_req),
        .ptr     (rr_wr_q),
        .gnt_idx (wr_pick),
        .any     (wr_any)
    );

    always_comb begin
        rd_state_d = rd_state_q;
        rd_gnt_d   = rd_gnt_q;
        rr_rd_d    = rr_rd_q;
        arid_d     = arid_q;
        unique case (rd_state_q)
            RD_IDLE: if (rd_any) begin
                rd_gnt_d   = rd_pick;
                rd_state_d = RD_ADDR;
            end
            RD_ADDR: if (m_arvalid && m_arready) begin
                arid_d     = m_arid;
                rd_state_d = RD_DATA;
            end
            RD_DATA: if (m_rvalid && m_rready && m_rlast) begin
                rr_rd_d    = W_IDX'(rr_wrap(int'(rd_gnt_q) + 1, N_REQ));
                rd_state_d = RD_IDLE;
            end
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // AW and W complete independently; the done flags stop a finished channel re-firing.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_gnt_d   = wr_gnt_q;
        rr_wr_d    = rr_wr_q;
        aw_done_d  = aw_done_q;
        w_done_d   = w_done_q;
        awid_d     = awid_q;
        unique case (wr_state_q)
            WR_IDLE: if (wr_any) begin
                wr_gnt_d   = wr_pick;
                aw_done_d  = 1'b0;
                w_done_d   = 1'b0;
                wr_state_d = WR_XFER;
            end
            WR_XFER: begin
                if (m_awvalid && m_awready) begin
                    aw_done_d = 1'b1;
                    awid_d    = m_awid;
                end
                if (m_wvalid && m_wready) w_done_d = 1'b1;
                if (aw_done_d && w_done_d) wr_state_d = WR_RESP;
            end
            WR_RESP: if (m_bvalid && m_bready) begin
                rr_wr_d    = W_IDX'(rr_wrap(int'(wr_gnt_q) + 1, N_REQ));
                wr_state_d = WR_IDLE;
            end
            default: wr_state_d = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q <= RD_IDLE;
            wr_state_q <= WR_IDLE;
            rd_gnt_q   <= '0;
            wr_gnt_q   <= '0;
            rr_rd_q    <= '0;
            rr_wr_q    <= '0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
            arid_q     <= '0;
            awid_q     <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            wr_state_q <= wr_state_d;
            rd_gnt_q   <= rd_gnt_d;
            wr_gnt_q   <= wr_gnt_d;
            rr_rd_q    <= rr_rd_d;
            rr_wr_q    <= rr_wr_d;
            aw_done_q  <= aw_done_d;
            w_done_q   <= w_done_d;
            arid_q     <= arid_d;
            awid_q     <= awid_d;
        end
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            s_arready[i] = 1'b0;
            s_rvalid[i]  = 1'b0;
            s_rid[i]     = '0;
            s_rdata[i]   = '0;
            s_rlast[i]   = 1'b0;
            s_rresp[i]   = AXI_RESP_OKAY;
        end
        m_arvalid = 1'b0;
        m_arid    = '0;
        m_araddr  = '0;
        m_arburst = '0;
        m_arsize  = '0;
        m_arlen   = '0;
        m_rready  = 1'b0;
        unique case (rd_state_q)
            RD_ADDR: begin
                m_arvalid           = s_arvalid[rd_gnt_q];
                m_arid              = s_arid[rd_gnt_q];
                m_araddr            = s_araddr[rd_gnt_q];
                m_arburst           = s_arburst[rd_gnt_q];
                m_arsize            = s_arsize[rd_gnt_q];
                m_arlen             = s_arlen[rd_gnt_q];
                s_arready[rd_gnt_q] = m_arready;
            end
            RD_DATA: begin
                s_rvalid[rd_gnt_q] = m_rvalid;
                s_rid[rd_gnt_q]    = m_rid;
                s_rdata[rd_gnt_q]  = m_rdata;
                s_rlast[rd_gnt_q]  = m_rlast;
                s_rresp[rd_gnt_q]  = m_rresp;
                m_rready           = s_rready[rd_gnt_q];
            end
            default: ;
        endcase
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            s_awready[i] = 1'b0;
            s_wready[i]  = 1'b0;
            s_bvalid[i]  = 1'b0;
            s_bid[i]     = '0;
            s_bresp[i]   = AXI_RESP_OKAY;
        end
        m_awvalid = 1'b0;
        m_awid    = '0;
        m_awaddr  = '0;
        m_awsize  = '0;
        m_awlen   = '0;
        m_wvalid  = 1'b0;
        m_wdata   = '0;
        m_wstrb   = '0;
        m_wlast   = 1'b0;
        m_bready  = 1'b0;
        unique case (wr_state_q)
            WR_XFER: begin
                m_awvalid           = s_awvalid[wr_gnt_q] && !aw_done_q;
                m_awid              = s_awid[wr_gnt_q];
                m_awaddr            = s_awaddr[wr_gnt_q];
                m_awsize            = s_awsize[wr_gnt_q];
                m_awlen             = s_awlen[wr_gnt_q];
                s_awready[wr_gnt_q] = m_awready && !aw_done_q;
                m_wvalid            = s_wvalid[wr_gnt_q] && !w_done_q;
                m_wdata             = s_wdata[wr_gnt_q];
                m_wstrb             = s_wstrb[wr_gnt_q];
                m_wlast             = s_wlast[wr_gnt_q];
                s_wready[wr_gnt_q]  = m_wready && !w_done_q;
            end
            WR_RESP: begin
                s_bvalid[wr_gnt_q] = m_bvalid;
                s_bid[wr_gnt_q]    = m_bid;
                s_bresp[wr_gnt_q]  = m_bresp;
                m_bready           = s_bready[wr_gnt_q];
            end
            default: ;
        endcase
    end

    assign rd_busy    = (rd_state_q != RD_IDLE);
    assign wr_busy    = (wr_state_q != WR_IDLE);
    assign rd_gnt_idx = rd_gnt_q;
    assign wr_gnt_idx = wr_gnt_q;

    // Protocol checks; the arid/awid copies exist only to tie responses back to requests.
    a_rid_match: assert property (@(posedge clk) disable iff (!rst_n)
        (rd_state_q == RD_DATA && m_rvalid && m_rready) |-> (m_rid == arid_q));
    a_bid_match: assert property (@(posedge clk) disable iff (!rst_n)
        (wr_state_q == WR_RESP && m_bvalid && m_bready) |-> (m_bid == awid_q));

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_chk
        a_awlen_zero: assert property (@(posedge clk) disable iff (!rst_n)
            s_awvalid[gi] |-> (s_awlen[gi] == 8'd0));
        a_arlen_zero: assert property (@(posedge clk) disable iff (!rst_n)
            s_arvalid[gi] |-> (s_arlen[gi] == 8'd0));
        a_valid_known: assert property (@(posedge clk) disable iff (!rst_n)
            !$isunknown({s_awvalid[gi], s_wvalid[gi], s_arvalid[gi], s_rvalid[gi], s_bvalid[gi]}));
    end

endmodule

// File: tb/tb_scr1_tb_axi_arbiter.sv
// Directed bench for scr1_tb_axi_arbiter with a single-port memory model and response scoreboards.
module tb_scr1_tb_axi_arbiter;
    import scr1_tb_axi_arb_pkg::*;

    localparam int N = 2;

    logic clk, rst_n;
    logic        s_awvalid [N]; logic [3:0]  s_awid [N]; logic [31:0] s_awaddr [N];
    logic [2:0]  s_awsize [N];  logic [7:0]  s_awlen [N]; logic s_awready [N];
    logic        s_wvalid [N];  logic [31:0] s_wdata [N]; logic [3:0] s_wstrb [N];
    logic        s_wlast [N];   logic s_wready [N];
    logic        s_bready [N];  logic s_bvalid [N]; logic [3:0] s_bid [N]; logic [1:0] s_bresp [N];
    logic        s_arvalid [N]; logic [3:0]  s_arid [N]; logic [31:0] s_araddr [N];
    logic [1:0]  s_arburst [N]; logic [2:0]  s_arsize [N]; logic [7:0] s_arlen [N];
    logic        s_arready [N];
    logic        s_rready [N];  logic s_rvalid [N]; logic [3:0] s_rid [N]; logic [31:0] s_rdata [N];
    logic        s_rlast [N];   logic [1:0]  s_rresp [N];
    logic        m_awvalid, m_awready, m_wvalid, m_wlast, m_wready, m_bvalid, m_bready;
    logic [3:0]  m_awid, m_bid, m_arid, m_rid, m_wstrb;
    logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
    logic [2:0]  m_awsize, m_arsize;
    logic [7:0]  m_awlen, m_arlen;
    logic [1:0]  m_bresp, m_arburst, m_rresp;
    logic        m_arvalid, m_arready, m_rvalid, m_rlast, m_rready;
    logic        rd_busy, wr_busy;
    logic [0:0]  rd_gnt_idx, wr_gnt_idx;

    scr1_tb_axi_arbiter #(.N_REQ(N), .W_ID(4), .W_ADR(32), .W_DATA(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_awvalid(s_awvalid), .s_awid(s_awid), .s_awaddr(s_awaddr), .s_awsize(s_awsize),
        .s_awlen(s_awlen), .s_awready(s_awready),
        .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s_wready(s_wready),
        .s_bready(s_bready), .s_bvalid(s_bvalid), .s_bid(s_bid), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arid(s_arid), .s_araddr(s_araddr), .s_arburst(s_arburst),
        .s_arsize(s_arsize), .s_arlen(s_arlen), .s_arready(s_arready),
        .s_rready(s_rready), .s_rvalid(s_rvalid), .s_rid(s_rid), .s_rdata(s_rdata),
        .s_rlast(s_rlast), .s_rresp(s_rresp),
        .m_awvalid(m_awvalid), .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awsize(m_awsize),
        .m_awlen(m_awlen), .m_awready(m_awready),
        .m_wvalid(m_wvalid), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wready(m_wready),
        .m_bvalid(m_bvalid), .m_bid(m_bid), .m_bresp(m_bresp), .m_bready(m_bready),
        .m_arvalid(m_arvalid), .m_arid(m_arid), .m_araddr(m_araddr), .m_arburst(m_arburst),
        .m_arsize(m_arsize), .m_arlen(m_arlen), .m_arready(m_arready),
        .m_rvalid(m_rvalid), .m_rid(m_rid), .m_rdata(m_rdata), .m_rlast(m_rlast),
        .m_rresp(m_rresp), .m_rready(m_rready),
        .rd_busy(rd_busy), .wr_busy(wr_busy), .rd_gnt_idx(rd_gnt_idx), .wr_gnt_idx(wr_gnt_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: one outstanding read and one outstanding write, response one cycle later.
    logic [31:0] mem [256];
    logic        rd_pend, aw_got, w_got, b_pend;
    logic [3:0]  rd_id, wr_id;
    logic [31:0] rd_word, wr_word, wr_addr;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 | i;
        mem[8'h40] = 32'hDEAD_BEEF;
    end

    assign m_arready = !rd_pend;
    assign m_rvalid  = rd_pend;
    assign m_rid     = rd_id;
    assign m_rdata   = rd_word;
    assign m_rlast   = 1'b1;
    assign m_rresp   = 2'b00;
    assign m_awready = !aw_got && !b_pend;
    assign m_wready  = !w_got && !b_pend;
    assign m_bvalid  = b_pend;
    assign m_bid     = wr_id;
    assign m_bresp   = 2'b00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_pend <= 1'b0; aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0;
            rd_id <= '0; wr_id <= '0; rd_word <= '0; wr_word <= '0; wr_addr <= '0;
        end else begin
            if (m_arvalid && m_arready) begin
                rd_pend <= 1'b1; rd_id <= m_arid; rd_word <= mem[m_araddr[9:2]];
            end else if (m_rvalid && m_rready) rd_pend <= 1'b0;
            if (m_awvalid && m_awready) begin aw_got <= 1'b1; wr_addr <= m_awaddr; wr_id <= m_awid; end
            if (m_wvalid && m_wready) begin w_got <= 1'b1; wr_word <= m_wdata; end
            if (aw_got && w_got) begin
                mem[wr_addr[9:2]] <= wr_word; aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b1;
            end
            if (m_bvalid && m_bready) b_pend <= 1'b0;
        end
    end

    typedef struct { int m; logic [3:0] id; logic [31:0] data; } rexp_t;
    typedef struct { int m; logic [3:0] id; logic [1:0] resp; } bexp_t;
    rexp_t rd_exp [$];
    bexp_t b_exp  [$];
    int    gnt_log [$];
    int    n_assert = 0, n_fail = 0;
    int    aw_hs = 0, w_hs = 0, overlap = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return 32'hA000_0000 | {24'h0, a[9:2]};
    endfunction

    // Response monitor: pops the scoreboards on upstream R/B handshakes.
    always @(negedge clk) begin
        rexp_t re;
        bexp_t be;
        if (rst_n) begin
            for (int m = 0; m < N; m++) begin
                if (s_rvalid[m] && s_rready[m]) begin
                    if (rd_exp.size() == 0) chk("r_unexpected", 1, 0);
                    else begin
                        re = rd_exp.pop_front();
                        chk("r_master", m, re.m);
                        chk("r_id", s_rid[m], re.id);
                        chk("r_data", s_rdata[m], re.data);
                        chk("r_last", s_rlast[m], 1);
                    end
                end
                if (s_bvalid[m] && s_bready[m]) begin
                    if (b_exp.size() == 0) chk("b_unexpected", 1, 0);
                    else begin
                        be = b_exp.pop_front();
                        chk("b_master", m, be.m);
                        chk("b_id", s_bid[m], be.id);
                        chk("b_resp", s_bresp[m], be.resp);
                    end
                end
            end
            if (m_arvalid && m_arready) gnt_log.push_back(int'(rd_gnt_idx));
            if (m_awvalid && m_awready) aw_hs++;
            if (m_wvalid && m_wready) w_hs++;
            if (rd_busy && wr_busy) overlap++;
        end
    end

    task automatic do_read(input int m, input logic [31:0] a, input logic [3:0] id,
                           input logic [31:0] exp_data, input bit push);
        bit ok = 0;
        s_arvalid[m] = 1'b1; s_araddr[m] = a; s_arid[m] = id;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (s_arready[m]) begin ok = 1; break; end
        end
        chk("ar_handshake", ok, 1);
        if (push) rd_exp.push_back('{m, id, exp_data});
        @(posedge clk); #1;
        s_arvalid[m] = 1'b0;
    endtask

    task automatic do_write(input int m, input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] id, input int w_lead);
        fork
            begin
                bit okw = 0;
                s_wvalid[m] = 1'b1; s_wdata[m] = d; s_wstrb[m] = 4'hF; s_wlast[m] = 1'b1;
                for (int k = 0; k < 64; k++) begin
                    @(negedge clk);
                    if (s_wready[m]) begin okw = 1; break; end
                end
                chk("w_handshake", okw, 1);
                @(posedge clk); #1;
                s_wvalid[m] = 1'b0;
            end
            begin
                bit oka = 0;
                repeat (w_lead) @(posedge clk);
                if (w_lead > 0) #1;
                s_awvalid[m] = 1'b1; s_awaddr[m] = a; s_awid[m] = id;
                for (int k = 0; k < 64; k++) begin
                    @(negedge clk);
                    if (s_awready[m]) begin oka = 1; break; end
                end
                chk("aw_handshake", oka, 1);
                if (oka) b_exp.push_back('{m, id, AXI_RESP_OKAY});
                @(posedge clk); #1;
                s_awvalid[m] = 1'b0;
            end
        join
    endtask

    task automatic wait_drain();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (rd_exp.size() == 0 && b_exp.size() == 0) break;
        end
        chk("drain_pending", rd_exp.size() + b_exp.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst_n = 1'b0;
        for (int m = 0; m < N; m++) begin
            s_awvalid[m] = 0; s_awid[m] = 0; s_awaddr[m] = 0; s_awsize[m] = 3'd2; s_awlen[m] = 0;
            s_wvalid[m] = 0; s_wdata[m] = 0; s_wstrb[m] = 0; s_wlast[m] = 0; s_bready[m] = 1;
            s_arvalid[m] = 0; s_arid[m] = 0; s_araddr[m] = 0; s_arburst[m] = 2'b01;
            s_arsize[m] = 3'd2; s_arlen[m] = 0; s_rready[m] = 1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rd_busy", rd_busy, 0);
        chk("rst_wr_busy", wr_busy, 0);
        chk("rst_rd_gnt", rd_gnt_idx, 0);
        chk("rst_wr_gnt", wr_gnt_idx, 0);
        chk("rst_s_arready1", s_arready[1], 0);
        chk("rst_s_awready0", s_awready[0], 0);
        chk("rst_m_arvalid", m_arvalid, 0);
        chk("rst_m_awvalid", m_awvalid, 0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Single read from master 1
        @(posedge clk); #1;
        s_arvalid[1] = 1; s_araddr[1] = 32'h100; s_arid[1] = 4'd3;
        @(negedge clk);
        chk("single_arready_early", s_arready[1], 0);
        @(negedge clk);
        chk("single_arready", s_arready[1], 1);
        chk("single_arready_other", s_arready[0], 0);
        chk("single_gnt", rd_gnt_idx, 1);
        rd_exp.push_back('{1, 4'd3, 32'hDEAD_BEEF});
        @(posedge clk); #1 s_arvalid[1] = 0;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (s_rvalid[1]) begin
                seen = 1;
                chk("single_rvalid_other", s_rvalid[0], 0);
            end
        end
        chk("single_rvalid_seen", seen, 1);
        wait_drain();

        // Contention: both masters request continuously
        gnt_log.delete();
        fork
            begin
                do_read(0, 32'h40, 4'h1, init_word(32'h40), 1);
                do_read(0, 32'h44, 4'h2, init_word(32'h44), 1);
            end
            begin
                do_read(1, 32'h48, 4'h3, init_word(32'h48), 1);
                do_read(1, 32'h4C, 4'h4, init_word(32'h4C), 1);
            end
        join
        wait_drain();
        chk("rr_count", gnt_log.size(), 4);
        if (gnt_log.size() == 4) begin
            for (int j = 0; j < 4; j++) chk("rr_order", gnt_log[j], j % 2);
            for (int j = 1; j < 4; j++) chk("rr_no_repeat", gnt_log[j] != gnt_log[j-1], 1);
        end

        // Write with W leading AW by two cycles, then read it back
        aw_hs = 0; w_hs = 0;
        fork
            do_write(0, 32'h200, 32'h1234_5678, 4'h5, 2);
            begin
                @(negedge clk); chk("w_early_wready", s_wready[0], 0);
                @(negedge clk); chk("w_early_wready", s_wready[0], 0);
            end
        join
        wait_drain();
        chk("aw_hs_count", aw_hs, 1);
        chk("w_hs_count", w_hs, 1);
        do_read(0, 32'h200, 4'h2, 32'h1234_5678, 1);
        wait_drain();

        // Concurrent write (master 0) and read (master 1)
        overlap = 0;
        fork
            do_write(0, 32'h300, 32'hCAFE_F00D, 4'h1, 0);
            do_read(1, 32'h304, 4'h7, init_word(32'h304), 1);
        join
        wait_drain();
        chk("overlap_busy", overlap >= 2, 1);
        do_read(1, 32'h300, 4'h9, 32'hCAFE_F00D, 1);
        wait_drain();

        // R backpressure on master 1 while master 0 waits for its grant
        s_rready[1] = 0;
        do_read(1, 32'h10, 4'h2, init_word(32'h10), 1);
        fork
            do_read(0, 32'h14, 4'h4, init_word(32'h14), 1);
            begin
                seen = 0;
                for (int k = 0; k < 20 && !seen; k++) begin
                    @(negedge clk);
                    seen = s_rvalid[1];
                end
                chk("bp_rvalid_seen", seen, 1);
                for (int j = 0; j < 5; j++) begin
                    chk("bp_m_rready", m_rready, 0);
                    chk("bp_rdata_stable", s_rdata[1], init_word(32'h10));
                    chk("bp_ar0_blocked", s_arready[0], 0);
                    @(negedge clk);
                end
                @(posedge clk); #1 s_rready[1] = 1;
            end
        join
        wait_drain();

        // Reset while the read path sits in RD_DATA
        s_rready[0] = 0;
        do_read(0, 32'h18, 4'h1, 32'h0, 0);
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = s_rvalid[0];
        end
        chk("rst_mid_rvalid_seen", seen, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_mid_s_rvalid", s_rvalid[0], 0);
        chk("rst_mid_m_rready", m_rready, 0);
        chk("rst_mid_rd_busy", rd_busy, 0);
        chk("rst_mid_m_arvalid", m_arvalid, 0);
        chk("rst_mid_s_arready", s_arready[0], 0);
        @(posedge clk); #1;
        rst_n = 1'b1; s_rready[0] = 1;
        do_read(0, 32'h100, 4'h6, 32'hDEAD_BEEF, 1);
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
